mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_rsp_tag_pipe.sv | 32 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the CPU/DMA memory arbiter.
// Holds the response owner tag and the default widths and starvation limit.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_XLEN         = 32;
    localparam int DEF_MEM_LAT      = 1;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    // Byte write enables seen by the RAM: strobes only apply to writes.
    function automatic logic [3:0] byte_we(input logic we, input logic [3:0] strb);
        logic [3:0] res;
        if (we) begin
            res = strb;
        end else begin
            res = 4'b0000;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_rsp_tag_pipe.sv
// Fixed-depth shift pipe carrying the owner of each RAM access so read data
// can be steered back to the right master when it emerges from the RAM.
module rsp_tag_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   clr,
    input  owner_e tag_in,
    output owner_e tag_out
);

    owner_e pipe_r [DEPTH];

    // Shift one tag per cycle; a clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= OWN_NONE;
            end
        end else begin
            pipe_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tag_out = pipe_r[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (CPU, DMA) arbiter onto a single-port RAM with fixed read latency.
// CPU has priority until the DMA has been denied STARVE_LIMIT cycles in a row.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int XLEN         = DEF_XLEN,
    parameter int MEM_LAT      = DEF_MEM_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [XLEN-1:0]   cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [XLEN-1:0]   cpu_rdata,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [XLEN-1:0]   dma_wdata,
    input  logic [3:0]        dma_wstrb,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [XLEN-1:0]   dma_rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int                WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              cpu_win_s;
    logic              dma_win_s;
    owner_e            tag_in_s;
    owner_e            tag_out_s;

    // Arbitration: CPU wins unless the DMA is also asking and has starved.
    always_comb begin
        cpu_win_s = 1'b0;
        dma_win_s = 1'b0;
        if (rst) begin
            cpu_win_s = 1'b0;
            dma_win_s = 1'b0;
        end else if (cpu_req && (!dma_req || (wait_cnt_r < LIMIT_C))) begin
            cpu_win_s = 1'b1;
        end else if (dma_req) begin
            dma_win_s = 1'b1;
        end else begin
            cpu_win_s = 1'b0;
            dma_win_s = 1'b0;
        end
    end

    // Count consecutive cycles the DMA is held off, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (!dma_req || dma_win_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (wait_cnt_r != LIMIT_C) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // RAM port mux and owner tag for the access issued this cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {XLEN{1'b0}};
        tag_in_s  = OWN_NONE;
        case ({cpu_win_s, dma_win_s})
            2'b10: begin
                mem_en    = 1'b1;
                mem_we    = byte_we(cpu_we, cpu_wstrb);
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (cpu_we) begin
                    tag_in_s = OWN_NONE;
                end else begin
                    tag_in_s = OWN_CPU;
                end
            end
            2'b01: begin
                mem_en    = 1'b1;
                mem_we    = byte_we(dma_we, dma_wstrb);
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                if (dma_we) begin
                    tag_in_s = OWN_NONE;
                end else begin
                    tag_in_s = OWN_DMA;
                end
            end
            default: begin
                mem_en    = 1'b0;
                mem_we    = 4'b0000;
                mem_addr  = {ADDR_W{1'b0}};
                mem_wdata = {XLEN{1'b0}};
                tag_in_s  = OWN_NONE;
            end
        endcase
    end

    assign cpu_gnt = cpu_win_s;
    assign dma_gnt = dma_win_s;

    rsp_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .clr     (rst),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    // Read data is valid for whichever master owns the tag leaving the pipe.
    always_comb begin
        cpu_rvalid = 1'b0;
        dma_rvalid = 1'b0;
        if (!rst) begin
            case (tag_out_s)
                OWN_CPU: cpu_rvalid = 1'b1;
                OWN_DMA: dma_rvalid = 1'b1;
                default: begin
                    cpu_rvalid = 1'b0;
                    dma_rvalid = 1'b0;
                end
            endcase
        end else begin
            cpu_rvalid = 1'b0;
            dma_rvalid = 1'b0;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a RAM model and a reference
// model of the arbitration and memory contents.
module tb_mem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int XLEN         = 32;
    localparam int MEM_LAT      = 2;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [XLEN-1:0]   cpu_wdata, cpu_rdata;
    logic [3:0]        cpu_wstrb;
    logic              dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [ADDR_W-1:0] dma_addr;
    logic [XLEN-1:0]   dma_wdata, dma_rdata;
    logic [3:0]        dma_wstrb;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .XLEN(XLEN), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_wstrb(dma_wstrb), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] a;
        a = 32'(i) << 2;
        if (a >= 32'h200 && a <= 32'h20C) return 32'h1111_1111 * (((a - 32'h200) >> 2) + 32'd1);
        if (a == 32'h400) return 32'h0000_0001;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RAM model with MEM_LAT read latency
    logic [31:0]     ram     [1024];
    logic [XLEN-1:0] rd_pipe [MEM_LAT];
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
        end else if (mem_en && mem_we != 4'b0000) begin
            ram[mem_addr[11:2]] <= merge(ram[mem_addr[11:2]], mem_wdata, mem_we);
        end
        rd_pipe[0] <= (mem_en && mem_we == 4'b0000) ? ram[mem_addr[11:2]] : 32'hDEAD_BEEF;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Scoreboard / reference model
    typedef struct {
        int          own;   // 1 = CPU, 2 = DMA
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [1024];
    bit          contend = 1'b0;
    int          c_cpu, c_dma, gap, max_gap;

    initial begin
        int  cyc;
        int  starve;
        bit  pc, pd, we;
        logic [31:0] a, wd;
        logic [3:0]  st;
        exp_t e;
        cyc = 0;
        starve = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                starve = 0;
                for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
                chk("rst_gnt", {cpu_gnt, dma_gnt}, 0);
                chk("rst_mem", {mem_en, mem_we}, 0);
                chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
            end else begin
                // CPU keeps priority until the DMA has been refused STARVE_LIMIT times running
                pc = cpu_req && (!dma_req || starve < STARVE_LIMIT);
                pd = dma_req && !pc;
                chk("cpu_gnt", cpu_gnt, pc);
                chk("dma_gnt", dma_gnt, pd);
                chk("mem_en", mem_en, pc || pd);
                if (pc || pd) begin
                    we = pc ? cpu_we    : dma_we;
                    a  = pc ? cpu_addr  : dma_addr;
                    wd = pc ? cpu_wdata : dma_wdata;
                    st = pc ? cpu_wstrb : dma_wstrb;
                    chk("mem_addr", mem_addr, a);
                    chk("mem_we", mem_we, we ? st : 4'b0000);
                    if (we) begin
                        chk("mem_wdata", mem_wdata, wd);
                        ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], wd, st);
                    end else begin
                        e.own  = pc ? 1 : 2;
                        e.data = ref_mem[a[11:2]];
                        e.due  = cyc + MEM_LAT;
                        exp_q.push_back(e);
                    end
                end else begin
                    chk("idle_mem_we", mem_we, 4'b0000);
                end
                starve = (dma_req && !pd) ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    chk("rsp_cycle", cyc, e.due);
                    chk("cpu_rvalid", cpu_rvalid, e.own == 1);
                    chk("dma_rvalid", dma_rvalid, e.own == 2);
                    chk("rdata", (e.own == 1) ? cpu_rdata : dma_rdata, e.data);
                end else begin
                    chk("no_rvalid", {cpu_rvalid, dma_rvalid}, 0);
                end
                if (contend) begin
                    if (cpu_gnt) c_cpu++;
                    if (dma_gnt) begin
                        c_dma++;
                        gap = 0;
                    end else begin
                        gap++;
                        if (gap > max_gap) max_gap = gap;
                    end
                end
            end
        end
    end

    // Masters: hold the request until granted, optionally wait for read data
    task automatic cpu_do(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input bit get_rd, output logic [31:0] rd);
        int n;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_wstrb = strb;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_gnt && n < 64);
        if (!cpu_gnt) chk("cpu_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        rd = '0;
        if (get_rd && !we) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!cpu_rvalid && n < 16);
            if (!cpu_rvalid) chk("cpu_rvalid_timeout", 0, 1);
            else rd = cpu_rdata;
            @(posedge clk); #1;
        end
    endtask

    task automatic dma_do(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input bit get_rd, output logic [31:0] rd);
        int n;
        dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd; dma_wstrb = strb;
        n = 0;
        do begin @(negedge clk); n++; end while (!dma_gnt && n < 64);
        if (!dma_gnt) chk("dma_gnt_timeout", 0, 1);
        @(posedge clk); #1;
        dma_req = 1'b0; dma_we = 1'b0;
        rd = '0;
        if (get_rd && !we) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!dma_rvalid && n < 16);
            if (!dma_rvalid) chk("dma_rvalid_timeout", 0, 1);
            else rd = dma_rdata;
            @(posedge clk); #1;
        end
    endtask

    task automatic rand_gap();
        int g;
        g = $urandom_range(0, 2);
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd2, junk;
        int dma_rv;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_wstrb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // CPU-only read
        cpu_do(1'b0, 32'h400, 32'h0, 4'hF, 1'b1, rd);
        chk("cpu_read_0x400", rd, 32'h0000_0001);

        // DMA block copy, then read back through the CPU
        for (int k = 0; k < 4; k++) begin
            dma_do(1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'hF, 1'b1, rd);
            dma_do(1'b1, 32'h300 + 32'(4 * k), rd, 4'hF, 1'b0, junk);
        end
        for (int k = 0; k < 4; k++) begin
            cpu_do(1'b0, 32'h300 + 32'(4 * k), 32'h0, 4'hF, 1'b1, rd);
            chk("dma_copy_dst", rd, 32'h1111_1111 * 32'(k + 1));
        end

        // Same-cycle CPU write and DMA read of one word
        cpu_do(1'b1, 32'h400, 32'h0, 4'hF, 1'b0, junk);
        fork
            cpu_do(1'b1, 32'h400, 32'h0000_0001, 4'hF, 1'b0, junk);
            dma_do(1'b0, 32'h400, 32'h0, 4'hF, 1'b1, rd2);
        join
        chk("dma_read_after_cpu_write", rd2, 32'h0000_0001);

        // Continuous contention
        c_cpu = 0; c_dma = 0; gap = 0; max_gap = 0;
        contend = 1'b1;
        fork
            for (int i = 0; i < 16; i++) cpu_do(1'b0, 32'h200 + 32'(4 * (i % 4)), 32'h0, 4'hF, 1'b0, junk);
            for (int i = 0; i < 4; i++)  dma_do(1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF, 1'b0, junk);
        join
        contend = 1'b0;
        chk("contend_cpu_grants", c_cpu, 16);
        chk("contend_dma_grants", c_dma, 4);
        chk("contend_max_gap", max_gap, STARVE_LIMIT);

        // Back-to-back alternating reads
        for (int i = 0; i < 8; i++) begin
            cpu_do(1'b0, 32'h200 + 32'(4 * (i % 4)), 32'h0, 4'hF, 1'b0, junk);
            dma_do(1'b0, 32'h300 + 32'(4 * ((i + 1) % 4)), 32'h0, 4'hF, 1'b0, junk);
        end

        // Random traffic from both masters
        fork
            for (int i = 0; i < 40; i++) begin
                rand_gap();
                cpu_do(1'($urandom_range(0, 1)), 32'h500 + 32'(4 * $urandom_range(0, 7)), $urandom,
                       4'($urandom_range(0, 15)), 1'b0, junk);
            end
            for (int i = 0; i < 40; i++) begin
                rand_gap();
                dma_do(1'($urandom_range(0, 1)), 32'h500 + 32'(4 * $urandom_range(0, 7)), $urandom,
                       4'($urandom_range(0, 15)), 1'b0, junk);
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Reset with a DMA read in flight and both masters requesting
        dma_do(1'b0, 32'h204, 32'h0, 4'hF, 1'b0, junk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h208;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20C;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("wait_cnt_in_rst", 64'(dut.wait_cnt_r), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cpu_gnt", cpu_gnt, 1'b1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("post_rst_dma_gnt", dma_gnt, 1'b1);
        @(posedge clk); #1;
        dma_req = 1'b0;
        dma_rv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dma_rvalid) dma_rv++;
        end
        chk("post_rst_dma_rvalid_count", dma_rv, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
